// File: rtl/uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_frame_arbiter
// Description : Round-robin arbiter sharing one byte-wide UART transmitter;
//               sends SYNC, ID, payload and XOR checksum per granted frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame_arbiter #(
    parameter int         NUM_REQ      = 2,
    parameter int         FRAME_BYTES  = 2,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         BUSY_TIMEOUT = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*FRAME_BYTES*8-1:0]   frame_data,
    input  logic [1:0]                         baud_sel_in,
    output logic [NUM_REQ-1:0]                 ack,
    output logic [NUM_REQ-1:0]                 done,
    output logic                               busy,
    output logic                               tx_start,
    output logic [7:0]                         tx_data,
    input  logic                               tx_busy,
    output logic [1:0]                         baud_sel,
    output logic [7:0]                         retry_count
);

    localparam int c_reqW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_payW     = FRAME_BYTES * 8;
    localparam int c_frameLen = FRAME_BYTES + 3;
    localparam int c_idxW     = $clog2(c_frameLen);
    localparam int c_timerW   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    localparam logic [c_idxW-1:0]   c_lastIdx  = c_idxW'(c_frameLen - 1);
    localparam logic [c_timerW-1:0] c_timerEnd = c_timerW'(BUSY_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0]  c_one      = NUM_REQ'(1);

    localparam logic [1:0] c_stIdle   = 2'd0;
    localparam logic [1:0] c_stSend   = 2'd1;
    localparam logic [1:0] c_stWaitHi = 2'd2;
    localparam logic [1:0] c_stWaitLo = 2'd3;

    logic [1:0]          r_state;
    logic [c_reqW-1:0]   r_last;
    logic [c_reqW-1:0]   r_winner;
    logic [c_idxW-1:0]   r_idx;
    logic [c_timerW-1:0] r_timer;
    logic [7:0]          r_frame [c_frameLen];

    logic [c_reqW-1:0]   w_win;
    int                  w_bestDist;
    logic [c_payW-1:0]   w_payload;
    logic [7:0]          w_id;
    logic [7:0]          w_checksum;

    // Distance 0 is the requester just after the last winner
    always_comb begin
        w_win      = '0;
        w_bestDist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (((i - int'(r_last) - 1 + 2 * NUM_REQ) % NUM_REQ) < w_bestDist)) begin
                w_bestDist = (i - int'(r_last) - 1 + 2 * NUM_REQ) % NUM_REQ;
                w_win      = c_reqW'(i);
            end
        end
    end

    always_comb begin
        w_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_reqW'(i)) begin
                w_payload = frame_data[i*c_payW +: c_payW];
            end
        end
    end

    assign w_id = 8'(w_win);

    always_comb begin
        w_checksum = w_id;
        for (int j = 0; j < FRAME_BYTES; j++) begin
            w_checksum = w_checksum ^ w_payload[j*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_stIdle;
            r_last      <= c_reqW'(NUM_REQ - 1);
            r_winner    <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            ack         <= '0;
            done        <= '0;
            busy        <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            baud_sel    <= 2'b00;
            retry_count <= '0;
            for (int j = 0; j < c_frameLen; j++) begin
                r_frame[j] <= '0;
            end
        end else begin
            ack      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
            case (r_state)
                c_stIdle: begin
                    baud_sel <= baud_sel_in;
                    if (|req) begin
                        r_frame[0] <= SYNC_BYTE;
                        r_frame[1] <= w_id;
                        for (int j = 0; j < FRAME_BYTES; j++) begin
                            r_frame[j+2] <= w_payload[j*8 +: 8];
                        end
                        r_frame[c_frameLen-1] <= w_checksum;
                        r_winner <= w_win;
                        r_last   <= w_win;
                        r_idx    <= '0;
                        ack      <= c_one << w_win;
                        busy     <= 1'b1;
                        r_state  <= c_stSend;
                    end
                end
                c_stSend: begin
                    tx_start <= 1'b1;
                    tx_data  <= r_frame[r_idx];
                    r_timer  <= '0;
                    r_state  <= c_stWaitHi;
                end
                c_stWaitHi: begin
                    if (tx_busy) begin
                        r_state <= c_stWaitLo;
                    end else if (r_timer == c_timerEnd) begin
                        // Transmitter never acknowledged: resend the same byte
                        if (retry_count != 8'hFF) begin
                            retry_count <= retry_count + 8'd1;
                        end
                        r_state <= c_stSend;
                    end else begin
                        r_timer <= r_timer + c_timerW'(1);
                    end
                end
                c_stWaitLo: begin
                    if (!tx_busy) begin
                        if (r_idx == c_lastIdx) begin
                            done    <= c_one << r_winner;
                            busy    <= 1'b0;
                            r_state <= c_stIdle;
                        end else begin
                            r_idx   <= r_idx + c_idxW'(1);
                            r_state <= c_stSend;
                        end
                    end
                end
                default: r_state <= c_stIdle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_frame_arbiter
// Description : Self-checking bench: transmitter model plus frame-level
//               reference model for the round-robin UART frame arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame_arbiter;

    localparam int         NUM_REQ      = 2;
    localparam int         FRAME_BYTES  = 2;
    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam int         BUSY_TIMEOUT = 15;
    localparam int         c_frameLen   = FRAME_BYTES + 3;
    localparam int         c_dataW      = NUM_REQ * FRAME_BYTES * 8;

    logic                 clk         = 1'b0;
    logic                 rst         = 1'b0;
    logic [NUM_REQ-1:0]   req         = '0;
    logic [c_dataW-1:0]   frame_data  = '0;
    logic [1:0]           baud_sel_in = 2'b00;
    logic                 tx_busy     = 1'b0;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [1:0]           baud_sel;
    logic [7:0]           retry_count;

    uart_tx_frame_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .FRAME_BYTES  (FRAME_BYTES),
        .SYNC_BYTE    (SYNC_BYTE),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .frame_data  (frame_data),
        .baud_sel_in (baud_sel_in),
        .ack         (ack),
        .done        (done),
        .busy        (busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .baud_sel    (baud_sel),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rrPick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return 0;
    endfunction

    // Inputs as seen by the DUT at the most recent rising edge
    logic [NUM_REQ-1:0] smpReq  = '0;
    logic [c_dataW-1:0] smpData = '0;
    logic [1:0]         smpBaud = 2'b00;
    logic               smpRst  = 1'b0;

    always @(posedge clk) begin
        smpReq  = req;
        smpData = frame_data;
        smpBaud = baud_sel_in;
        smpRst  = rst;
    end

    // Reference model state
    bit          inFrame     = 0;
    bit          lastIgnored = 0;
    bit          fellPrev    = 0;
    int          mLast       = NUM_REQ - 1;
    int          curW        = 0;
    int          pos         = 0;
    int          mRetries    = 0;
    int          sinceStart  = 0;
    int          busyCnt     = 0;
    int          ignoreUsed  = 0;
    logic [1:0]  frameBaud   = 2'b00;
    logic [7:0]  expBytes [c_frameLen];
    logic [7:0]  txLog [$];
    int          grantLog [$];

    // Written only by the stimulus process
    int          busyLen   = 20;
    int          ignoreReq = 0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] expAck;
        logic [NUM_REQ-1:0] expDone;
        logic [7:0]         sum;
        logic [7:0]         b;
        int                 w;
        if (!rst || !smpRst) begin
            inFrame = 0; lastIgnored = 0; fellPrev = 0;
            mLast = NUM_REQ - 1; mRetries = 0; pos = 0; busyCnt = 0; sinceStart = 0;
            tx_busy = 1'b0;
        end else begin
            expAck = '0;
            w      = 0;
            if (!inFrame && smpReq != '0) begin
                w      = rrPick(smpReq, mLast);
                expAck = NUM_REQ'(1) << w;
            end
            checkVal("ack", ack, expAck);

            expDone = (fellPrev && inFrame && pos == c_frameLen) ? (NUM_REQ'(1) << curW) : '0;
            checkVal("done", done, expDone);
            fellPrev = 0;
            if (expDone != '0) begin
                checkVal("busy_after_done", busy, 0);
                checkVal("baud_held_frame", baud_sel, frameBaud);
                inFrame = 0;
            end

            if (expAck != '0) begin
                checkVal("baud_at_grant", baud_sel, smpBaud);
                checkVal("busy_at_grant", busy, 1);
                inFrame = 1; curW = w; mLast = w; pos = 0; frameBaud = smpBaud;
                grantLog.push_back(w);
                expBytes[0] = SYNC_BYTE;
                expBytes[1] = 8'(w);
                sum = 8'(w);
                for (int j = 0; j < FRAME_BYTES; j++) begin
                    b = smpData[(w * FRAME_BYTES + j) * 8 +: 8];
                    expBytes[j+2] = b;
                    sum = sum ^ b;
                end
                expBytes[c_frameLen-1] = sum;
            end

            if (busyCnt > 0) begin
                busyCnt--;
                if (busyCnt == 0) begin
                    tx_busy  = 1'b0;
                    fellPrev = 1;
                end
            end

            if (tx_start) begin
                checkVal("start_in_frame", inFrame, 1);
                checkVal("tx_data", tx_data, (pos < c_frameLen) ? 32'(expBytes[pos]) : 32'hFFFF_FFFF);
                checkVal("retry_count", retry_count, mRetries);
                checkVal("busy_in_frame", busy, 1);
                checkVal("baud_in_frame", baud_sel, frameBaud);
                if (lastIgnored) checkVal("retry_gap", sinceStart, BUSY_TIMEOUT);
                sinceStart = 0;
                if (ignoreUsed < ignoreReq) begin
                    ignoreUsed++;
                    lastIgnored = 1;
                    if (mRetries < 255) mRetries++;
                end else begin
                    lastIgnored = 0;
                    txLog.push_back(tx_data);
                    pos++;
                    tx_busy = 1'b1;
                    busyCnt = busyLen;
                end
            end else begin
                sinceStart++;
            end
        end
    end

    task automatic waitAck(input string tag);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #2;
            if (ack != '0) return;
        end
        checkVal(tag, 0, 1);
    endtask

    task automatic waitDone(input string tag, output logic [NUM_REQ-1:0] seen);
        seen = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #2;
            if (done != '0) begin
                seen = done;
                return;
            end
        end
        checkVal(tag, 0, 1);
    endtask

    task automatic checkOutputsZero(input string tag);
        checkVal({tag, "_ack"}, ack, 0);
        checkVal({tag, "_done"}, done, 0);
        checkVal({tag, "_busy"}, busy, 0);
        checkVal({tag, "_tx_start"}, tx_start, 0);
        checkVal({tag, "_tx_data"}, tx_data, 0);
        checkVal({tag, "_baud_sel"}, baud_sel, 0);
        checkVal({tag, "_retry_count"}, retry_count, 0);
    endtask

    logic [7:0] f1Exp [5] = '{8'hA5, 8'h00, 8'h12, 8'h3C, 8'h2E};

    initial begin
        logic [NUM_REQ-1:0] d;
        int logStart;
        int gStart;

        repeat (3) @(posedge clk);
        #1 checkOutputsZero("reset");

        // Single frame
        @(negedge clk); #1;
        logStart   = txLog.size();
        frame_data = 32'h0000_3C12;
        req        = 2'b01;
        rst        = 1'b1;
        waitAck("f1_ack_timeout");
        checkVal("f1_ack", ack, 2'b01);
        req = '0;
        waitDone("f1_done_timeout", d);
        checkVal("f1_done", d, 2'b01);
        checkVal("f1_len", txLog.size() - logStart, 5);
        if (txLog.size() >= logStart + 5) begin
            for (int k = 0; k < 5; k++) checkVal("f1_byte", txLog[logStart+k], f1Exp[k]);
        end
        @(negedge clk); #2 checkVal("f1_busy_idle", busy, 0);

        // Contention from reset
        @(negedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        gStart  = grantLog.size();
        busyLen = 3;
        req     = 2'b11;
        rst     = 1'b1;
        for (int f = 0; f < 4; f++) waitDone("cont_done_timeout", d);
        req = '0;
        checkVal("cont_count", grantLog.size() - gStart, 4);
        if (grantLog.size() >= gStart + 4) begin
            for (int f = 0; f < 4; f++) checkVal("cont_grant", grantLog[gStart+f], f % 2);
        end

        // Busy timeout and retry
        repeat (2) @(negedge clk);
        #1;
        busyLen   = 4;
        ignoreReq = ignoreUsed + 1;
        req       = 2'b01;
        waitAck("to_ack_timeout");
        req = '0;
        waitDone("to_done_timeout", d);
        checkVal("to_done", d, 2'b01);
        checkVal("to_retry_count", retry_count, 1);

        // Baud select only follows in IDLE
        @(negedge clk); #1 req = 2'b10;
        waitAck("baud_ack_timeout");
        req = '0;
        repeat (4) @(negedge clk);
        #1 baud_sel_in = 2'b11;
        #1 checkVal("baud_mid", baud_sel, 2'b00);
        waitDone("baud_done_timeout", d);
        repeat (2) @(negedge clk);
        #2 checkVal("baud_idle", baud_sel, 2'b11);

        // Asynchronous reset in the middle of a frame
        @(negedge clk); #1;
        busyLen  = 10;
        logStart = txLog.size();
        req      = 2'b01;
        waitAck("mid_ack_timeout");
        req = '0;
        for (int i = 0; i < 2000 && txLog.size() < logStart + 3; i++) @(negedge clk);
        checkVal("mid_reached_byte3", txLog.size() >= logStart + 3, 1);
        @(posedge clk); #3 rst = 1'b0;
        #1 checkOutputsZero("async_rst");
        @(negedge clk); #1;
        logStart = txLog.size();
        gStart   = grantLog.size();
        req      = 2'b10;
        rst      = 1'b1;
        waitAck("post_rst_ack_timeout");
        req = '0;
        checkVal("post_rst_grant", (grantLog.size() > gStart) ? grantLog[gStart] : -1, 1);
        waitDone("post_rst_done_timeout", d);
        checkVal("post_rst_sync", (txLog.size() > logStart) ? 32'(txLog[logStart]) : 32'hFFFF_FFFF, 8'hA5);
        checkVal("post_rst_id", (txLog.size() > logStart + 1) ? 32'(txLog[logStart+1]) : 32'hFFFF_FFFF, 8'h01);

        // Request dropped right after ack
        @(negedge clk); #1 req = 2'b10;
        waitAck("drop_ack_timeout");
        checkVal("drop_ack", ack, 2'b10);
        req = '0;
        waitDone("drop_done_timeout", d);
        checkVal("drop_done", d, 2'b10);

        // Randomized frames with mid-frame input churn
        for (int it = 0; it < 40; it++) begin
            @(negedge clk); #1;
            busyLen     = $urandom_range(1, 6);
            if ($urandom_range(0, 4) == 0) ignoreReq = ignoreUsed + 1;
            baud_sel_in = 2'($urandom);
            frame_data  = c_dataW'($urandom);
            req         = NUM_REQ'($urandom);
            if (req == '0) begin
                repeat (3) @(negedge clk);
                continue;
            end
            waitAck("rnd_ack_timeout");
            repeat ($urandom_range(0, 4)) begin
                @(negedge clk); #1;
                req         = NUM_REQ'($urandom);
                frame_data  = c_dataW'($urandom);
                baud_sel_in = 2'($urandom);
            end
            req = '0;
            waitDone("rnd_done_timeout", d);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, compared %0d", nCompared);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame_arbiter.md
Name: uart_tx_frame_arbiter

Overview:
- Shares one RS-232 byte transmitter between NUM_REQ requesters, e.g. per-player move reporters and a status reporter.
- Grants requesters round-robin and latches the winner's payload.
- Sends a framed packet one byte at a time: SYNC, ID, payload bytes, checksum. It drives the transmitter's start/data/baud-select inputs and sequences on its busy output.
- Sits between game logic and the UART TX.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
FRAME_BYTES, 2, payload bytes per frame (1..16)
SYNC_BYTE, 8'hA5, first byte of every frame
BUSY_TIMEOUT, 15, cycles to wait for tx_busy to rise after tx_start before retrying the byte

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester frame request (level)
frame_data  in  NUM_REQ*FRAME_BYTES*8  payload; requester i slice starts at bit i*FRAME_BYTES*8, byte 0 in the LSBs
baud_sel_in  in  2  requested baud select
ack  out  NUM_REQ  one-cycle pulse: frame of requester i latched
done  out  NUM_REQ  one-cycle pulse: last byte of requester i's frame finished
busy  out  1  frame in progress
tx_start  out  1  to transmitter start
tx_data  out  8  to transmitter data
tx_busy  in  1  from transmitter busy
baud_sel  out  2  to transmitter BaudSelect; changes only in IDLE
retry_count  out  8  saturating count of busy-timeout retries

Behaviour:
- Reset (rst=0, async): state IDLE. ack, done, tx_start, busy, retry_count = 0; tx_data = 0; baud_sel = 2'b00; round-robin pointer last = NUM_REQ-1. Latched frame is discarded; a partial frame is abandoned, not resumed.
- States: IDLE, SEND, WAIT_HI, WAIT_LO. Outputs are registered.
- IDLE:
  - baud_sel <= baud_sel_in every cycle.
  - If any req bit is set, winner w = first set bit searching last+1, last+2, … modulo NUM_REQ.
  - At that edge: latch w's payload and w; last <= w; byte index <= 0; ack[w] pulses the next cycle; busy <= 1; go to SEND.
- Byte sequence (index 0..FRAME_BYTES+2):
  - index 0: SYNC_BYTE
  - index 1: ID = {5'b0, w[2:0]}
  - indices 2..FRAME_BYTES+1: payload bytes 0..FRAME_BYTES-1
  - last index: checksum = ID XOR all payload bytes
- SEND:
  - tx_start = 1 and tx_data = current byte for exactly one cycle.
  - tx_data holds its value until the next SEND.
  - Next state WAIT_HI; timeout counter cleared.
- WAIT_HI:
  - tx_busy = 1 → WAIT_LO.
  - Otherwise increment the counter. On reaching BUSY_TIMEOUT: retry_count++ (saturate at 255), return to SEND with the same index.
- WAIT_LO:
  - Wait for tx_busy = 0.
  - If the index is last: done[w] pulses, busy <= 0, go to IDLE.
  - Otherwise index++ and go to SEND.
- Minimum spacing between consecutive tx_start pulses is 3 cycles plus the transmitter's busy time.
- req is ignored outside IDLE. Dropping req after ack has no effect; a new req raised mid-frame waits.
- A req held continuously after done is re-eligible. The other requesters get priority because last = w.
- Simultaneous reqs in IDLE: exactly one ack, chosen by the round-robin rule.
- baud_sel_in changes mid-frame take effect at the next IDLE only.
- tx_busy already high on entry to SEND (another driver): not legal; behaviour is not defined beyond no lockup, since the timeout/retry path recovers.

Test Plan:
- Single frame: req=2'b01, frame_data[15:0]=16'h3C12, tx model busy 20 cycles per byte → tx_data sequence A5, 00, 12, 3C, 2E. ack[0] is 1 cycle after req; done[0] pulses after the 5th busy falls; busy returns to 0.
- Contention: req=2'b11 held from reset → grants 0,1,0,1 (ID bytes 00, 01, 00, 01); no overlapping frames; each ack is a single-cycle pulse.
- Timeout: tx model ignores the first tx_start → after 15 cycles in WAIT_HI, tx_start re-pulses with the same byte (A5); retry_count = 1; frame then completes normally.
- Baud: baud_sel_in=2'b11 set mid-frame → baud_sel stays 00 until done, then becomes 11 in IDLE before the next frame.
- Reset mid-frame: rst=0 during byte 3 → all outputs are 0 asynchronously. After release with req=2'b10, a fresh frame starts with A5 and ID 01, because the round-robin pointer was reset to NUM_REQ-1 and the search starts at 0.
- Request drop: req[1] deasserted the cycle after ack[1] → the full frame is still sent and done[1] pulses.
